ucode_loader: RTL and testbench

UCODE_LOADER -- requirements
Module: ucode_loader

---
 rtl/npu_pkg.sv | 36 +++
 rtl/ucode_loader.sv | 169 ++++++++++++++++
 tb/tb_ucode_loader.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/npu_pkg.sv
// Shared NPU definitions: the 128-bit microcode instruction layout, opcode
// constants, and the state encoding of the microcode loader.
package npu_pkg;

  localparam int WORD_WIDTH  = 32;
  localparam int INSTR_WIDTH = 128;

  localparam logic [7:0] OPCODE_NOP  = 8'h00;
  localparam logic [7:0] OPCODE_GEMM = 8'h01;
  localparam logic [7:0] OPCODE_CONV = 8'h02;
  localparam logic [7:0] OPCODE_ADD  = 8'h03;
  localparam logic [7:0] OPCODE_END  = 8'hFF;

  // Instruction fields, MSB to LSB; the opcode sits in lane 0, bits [7:0].
  typedef struct packed {
    logic [15:0] imm;
    logic [15:0] k;
    logic [15:0] n;
    logic [15:0] m;
    logic [15:0] src1;
    logic [15:0] src0;
    logic [15:0] dst;
    logic [7:0]  flags;
    logic [7:0]  opcode;
  } instruction_t;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_COLLECT,
    LD_WRITE,
    LD_LAUNCH,
    LD_RUN,
    LD_ERROR
  } loader_state_e;

endpackage

// File: rtl/ucode_loader.sv
// Microcode loader: gathers 32-bit host words into 128-bit instructions,
// writes them to the instruction SRAM from a captured base address, then
// launches the microcode controller and waits for it to finish.
// Optional build macro UCODE_LOADER_END_CHECK_EN: the last instruction must
// carry OPCODE_END, otherwise the session ends in ERROR after writing it.
module ucode_loader
  import npu_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_INSTR  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_begin,
  input  logic [ADDR_WIDTH-1:0] load_base_addr,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [31:0]           wr_data,
  input  logic                  wr_last,
  output logic                  sram_wr_en,
  output logic [ADDR_WIDTH-1:0] sram_wr_addr,
  output logic [127:0]          sram_wr_data,
  output logic                  ctrl_start,
  output logic [ADDR_WIDTH-1:0] ctrl_base_addr,
  output logic [15:0]           ctrl_length,
  input  logic                  ctrl_busy,
  input  logic                  ctrl_done,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  load_error,
  output logic [15:0]           instr_count
);

  localparam logic [15:0] MAX_COUNT = 16'(MAX_INSTR);

  loader_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [15:0]           count_q;
  logic [1:0]            idx_q;
  logic [127:0]          asm_q;
  logic                  last_q;
  logic                  session_open;
  logic                  launch_now;

`ifdef UCODE_LOADER_END_CHECK_EN
  instruction_t          instr;
  assign instr = instruction_t'(asm_q);
`endif

  // load_begin (re)opens a session from IDLE, COLLECT or WRITE only.
  assign session_open = load_begin &&
                        (state_q == LD_IDLE || state_q == LD_COLLECT || state_q == LD_WRITE);
  assign launch_now   = (state_q == LD_LAUNCH) && !ctrl_busy;
  assign instr_count  = count_q;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: registers are updated with <= so every flop samples pre-edge values
    // regardless of statement order; = here would create simulation races.
    if (rst) state_q <= LD_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; a missing default would infer a latch.
    state_d        = state_q;
    wr_ready       = 1'b0;
    sram_wr_en     = 1'b0;
    sram_wr_addr   = '0;
    sram_wr_data   = '0;
    ctrl_start     = 1'b0;
    ctrl_base_addr = '0;
    ctrl_length    = '0;
    load_busy      = (state_q != LD_IDLE);
    load_done      = 1'b0;
    load_error     = 1'b0;

    case (state_q)
      LD_IDLE: begin
        if (load_begin) state_d = LD_COLLECT;
      end
      LD_COLLECT: begin
        wr_ready = 1'b1;
        if (load_begin) begin
          state_d = LD_COLLECT;
        end else if (wr_valid) begin
          if (idx_q != 2'd3) begin
            if (wr_last) state_d = LD_ERROR;
          end else if (count_q == MAX_COUNT) begin
            state_d = LD_ERROR;
          end else begin
            state_d = LD_WRITE;
          end
        end
      end
      LD_WRITE: begin
        sram_wr_en   = 1'b1;
        sram_wr_addr = base_q + ADDR_WIDTH'(count_q);
        sram_wr_data = asm_q;
        if (load_begin) begin
          state_d = LD_COLLECT;
        end else if (last_q) begin
`ifdef UCODE_LOADER_END_CHECK_EN
          state_d = (instr.opcode == OPCODE_END) ? LD_LAUNCH : LD_ERROR;
`else
          state_d = LD_LAUNCH;
`endif
        end else begin
          state_d = LD_COLLECT;
        end
      end
      LD_LAUNCH: begin
        if (launch_now) begin
          ctrl_start     = 1'b1;
          ctrl_base_addr = base_q;
          ctrl_length    = count_q;
          state_d        = LD_RUN;
        end
      end
      LD_RUN: begin
        ctrl_base_addr = base_q;
        ctrl_length    = count_q;
        if (ctrl_done) begin
          load_done = 1'b1;
          state_d   = LD_IDLE;
        end
      end
      LD_ERROR: begin
        load_error = 1'b1;
        state_d    = LD_IDLE;
      end
      default: state_d = LD_IDLE;
    endcase
  end

  // Session datapath: base capture, lane assembly and instruction counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the assembly register is ordinary flops and is cleared here; the
      // SRAM itself is never reset, it simply stops receiving writes.
      base_q  <= '0;
      count_q <= '0;
      idx_q   <= '0;
      asm_q   <= '0;
      last_q  <= 1'b0;
    end else if (session_open) begin
      base_q  <= load_base_addr;
      count_q <= '0;
      idx_q   <= '0;
      asm_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        LD_COLLECT: begin
          if (wr_valid) begin
            asm_q[{idx_q, 5'd0} +: 32] <= wr_data;
            idx_q                      <= idx_q + 2'd1;
            if (idx_q == 2'd3) last_q <= wr_last;
          end
        end
        LD_WRITE: count_q <= count_q + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ucode_loader.sv
// Scoreboard bench for ucode_loader: stimulus pushes expected SRAM writes,
// controller starts, done and error pulses into a queue per DUT; a negedge
// monitor pops and compares whenever a DUT presents one of those events.
// A second instance with MAX_INSTR=2 is held in reset except for its own test.
module tb_ucode_loader;
  import npu_pkg::*;

  localparam int EV_WRITE = 0;
  localparam int EV_START = 1;
  localparam int EV_DONE  = 2;
  localparam int EV_ERROR = 3;

  typedef struct {
    int           kind;
    logic [15:0]  addr;
    logic [127:0] data;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst, rst2;
  logic         load_begin;
  logic [15:0]  load_base_addr;
  logic         wr_valid, wr_last;
  logic [31:0]  wr_data;
  logic         ctrl_busy, ctrl_done;
  logic         sel;

  logic         wr_ready, sram_wr_en, ctrl_start, load_busy, load_done, load_error;
  logic [15:0]  sram_wr_addr, ctrl_base_addr, ctrl_length, instr_count;
  logic [127:0] sram_wr_data;

  logic         wr_ready2, sram_wr_en2, ctrl_start2, load_busy2, load_done2, load_error2;
  logic [15:0]  sram_wr_addr2, ctrl_base_addr2, ctrl_length2, instr_count2;
  logic [127:0] sram_wr_data2;

  int vectors = 0;
  int miscompares = 0;
  ev_t q1[$];
  ev_t q2[$];

  instruction_t gemm_i, end_i, add_i;

  always #5 clk = ~clk;

  ucode_loader dut (
    .clk(clk), .rst(rst), .load_begin(load_begin), .load_base_addr(load_base_addr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
    .sram_wr_en(sram_wr_en), .sram_wr_addr(sram_wr_addr), .sram_wr_data(sram_wr_data),
    .ctrl_start(ctrl_start), .ctrl_base_addr(ctrl_base_addr), .ctrl_length(ctrl_length),
    .ctrl_busy(ctrl_busy), .ctrl_done(ctrl_done), .load_busy(load_busy),
    .load_done(load_done), .load_error(load_error), .instr_count(instr_count)
  );

  ucode_loader #(.ADDR_WIDTH(16), .MAX_INSTR(2)) dut2 (
    .clk(clk), .rst(rst2), .load_begin(load_begin), .load_base_addr(load_base_addr),
    .wr_valid(wr_valid), .wr_ready(wr_ready2), .wr_data(wr_data), .wr_last(wr_last),
    .sram_wr_en(sram_wr_en2), .sram_wr_addr(sram_wr_addr2), .sram_wr_data(sram_wr_data2),
    .ctrl_start(ctrl_start2), .ctrl_base_addr(ctrl_base_addr2), .ctrl_length(ctrl_length2),
    .ctrl_busy(ctrl_busy), .ctrl_done(ctrl_done), .load_busy(load_busy2),
    .load_done(load_done2), .load_error(load_error2), .instr_count(instr_count2)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ev_t ev(input int kind, input logic [15:0] addr, input logic [127:0] data);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    return e;
  endfunction

  function automatic int qsize(input int which);
    return (which == 1) ? q1.size() : q2.size();
  endfunction

  // Compare one observed DUT event against the head of that DUT's queue.
  task automatic observe(input int which, input logic en, input logic [15:0] a,
                         input logic [127:0] d, input logic st, input logic [15:0] cb,
                         input logic [15:0] cl, input logic dn, input logic er);
    ev_t act, exp;
    bit  have = 1'b1;
    if (en)      act = ev(EV_WRITE, a, d);
    else if (st) act = ev(EV_START, cb, {112'd0, cl});
    else if (dn) act = ev(EV_DONE, 16'd0, 128'd0);
    else if (er) act = ev(EV_ERROR, 16'd0, 128'd0);
    else         have = 1'b0;
    if (have) begin
      if (st) check($sformatf("dut%0d_start_while_busy", which), {127'd0, ctrl_busy}, 128'd0);
      if (qsize(which) == 0) begin
        check($sformatf("dut%0d_unexpected_event", which), 128'(act.kind), 128'hFFFF);
      end else begin
        exp = (which == 1) ? q1.pop_front() : q2.pop_front();
        check($sformatf("dut%0d_event_kind", which), 128'(act.kind), 128'(exp.kind));
        check($sformatf("dut%0d_event_addr", which), {112'd0, act.addr}, {112'd0, exp.addr});
        check($sformatf("dut%0d_event_data", which), act.data, exp.data);
      end
    end
  endtask

  // Monitor: samples both DUTs away from the rising edge.
  always @(negedge clk) begin
    observe(1, sram_wr_en, sram_wr_addr, sram_wr_data, ctrl_start, ctrl_base_addr,
            ctrl_length, load_done, load_error);
    observe(2, sram_wr_en2, sram_wr_addr2, sram_wr_data2, ctrl_start2, ctrl_base_addr2,
            ctrl_length2, load_done2, load_error2);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_load(input logic [15:0] base);
    load_begin     = 1'b1;
    load_base_addr = base;
    tick();
    load_begin     = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] data, input logic last);
    logic rdy;
    int   n = 0;
    wr_valid = 1'b1;
    wr_data  = data;
    wr_last  = last;
    do begin
      @(negedge clk);
      rdy = sel ? wr_ready2 : wr_ready;
      tick();
      n++;
    end while (!rdy && n < 50);
    if (!rdy) check("word_accept_timeout", 128'd0, 128'd1);
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic send_instr(input logic [127:0] v, input logic last);
    for (int k = 0; k < 4; k++) send_word(v[32*k +: 32], last && (k == 3));
  endtask

  task automatic drain(input int which, input int budget);
    int n = 0;
    while (qsize(which) != 0 && n < budget) begin
      tick();
      n++;
    end
    check($sformatf("dut%0d_queue_drained", which), 128'(qsize(which)), 128'd0);
  endtask

  // Controller finishes: expect load_done, then the loader is idle.
  task automatic finish_run();
    q1.push_back(ev(EV_DONE, 16'd0, 128'd0));
    ctrl_done = 1'b1;
    tick();
    ctrl_done = 1'b0;
    drain(1, 5);
    check("idle_after_run", {127'd0, load_busy}, 128'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    gemm_i = '{imm: 16'h0040, k: 16'd64, n: 16'd32, m: 16'd16, src1: 16'h2000,
               src0: 16'h1000, dst: 16'h3000, flags: 8'h01, opcode: OPCODE_GEMM};
    end_i  = '{imm: 16'h0, k: 16'h0, n: 16'h0, m: 16'h0, src1: 16'h0,
               src0: 16'h0, dst: 16'h0, flags: 8'h00, opcode: OPCODE_END};
    add_i  = '{imm: 16'h0005, k: 16'h0, n: 16'h0, m: 16'd8, src1: 16'h0200,
               src0: 16'h0100, dst: 16'h0300, flags: 8'h00, opcode: OPCODE_ADD};

    rst = 1'b1; rst2 = 1'b1; sel = 1'b0;
    load_begin = 1'b0; load_base_addr = '0;
    wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0;
    ctrl_busy = 1'b0; ctrl_done = 1'b0;
    repeat (3) tick();

    // Reset state.
    check("rst_load_busy",   {127'd0, load_busy},  128'd0);
    check("rst_wr_ready",    {127'd0, wr_ready},   128'd0);
    check("rst_instr_count", {112'd0, instr_count}, 128'd0);
    check("rst_sram_wr_en",  {127'd0, sram_wr_en}, 128'd0);
    rst = 1'b0;
    tick();

    // Words offered in IDLE are not consumed.
    wr_valid = 1'b1; wr_data = 32'hDEAD_BEEF;
    check("idle_wr_ready", {127'd0, wr_ready}, 128'd0);
    tick(); tick();
    check("idle_stays_idle", {127'd0, load_busy}, 128'd0);
    wr_valid = 1'b0;

    // GEMM + END at 0x0100, controller free.
    q1.push_back(ev(EV_WRITE, 16'h0100, gemm_i));
    q1.push_back(ev(EV_WRITE, 16'h0101, end_i));
    q1.push_back(ev(EV_START, 16'h0100, 128'd2));
    begin_load(16'h0100);
    check("collect_busy", {127'd0, load_busy}, 128'd1);
    send_instr(gemm_i, 1'b0);
    send_instr(end_i, 1'b1);
    drain(1, 40);
    check("run_ctrl_base",   {112'd0, ctrl_base_addr}, 128'h0100);
    check("run_ctrl_length", {112'd0, ctrl_length},    128'd2);
    check("run_instr_count", {112'd0, instr_count},    128'd2);
    finish_run();

    // Same program, controller busy for 10 cycles after the last word.
    ctrl_busy = 1'b1;
    q1.push_back(ev(EV_WRITE, 16'h0100, gemm_i));
    q1.push_back(ev(EV_WRITE, 16'h0101, end_i));
    q1.push_back(ev(EV_START, 16'h0100, 128'd2));
    begin_load(16'h0100);
    send_instr(gemm_i, 1'b0);
    send_instr(end_i, 1'b1);
    repeat (10) tick();
    check("start_held_while_busy", 128'(q1.size()), 128'd1);
    ctrl_busy = 1'b0;
    drain(1, 5);
    finish_run();

    // wr_last on word 6 (lane 1 of the second instruction).
    q1.push_back(ev(EV_WRITE, 16'h0300, gemm_i));
    q1.push_back(ev(EV_ERROR, 16'd0, 128'd0));
    begin_load(16'h0300);
    send_instr(gemm_i, 1'b0);
    send_word(end_i[31:0], 1'b0);
    send_word(end_i[63:32], 1'b1);
    drain(1, 10);
    check("idle_after_error", {127'd0, load_busy}, 128'd0);

    // Last instruction is not END.
    q1.push_back(ev(EV_WRITE, 16'h0380, add_i));
`ifdef UCODE_LOADER_END_CHECK_EN
    q1.push_back(ev(EV_ERROR, 16'd0, 128'd0));
`else
    q1.push_back(ev(EV_START, 16'h0380, 128'd1));
`endif
    begin_load(16'h0380);
    send_instr(add_i, 1'b1);
    drain(1, 10);
`ifndef UCODE_LOADER_END_CHECK_EN
    finish_run();
`endif

    // Reset after two words, then a fresh session at 0x0200.
    begin_load(16'h0400);
    send_word(gemm_i[31:0], 1'b0);
    send_word(gemm_i[63:32], 1'b0);
    rst = 1'b1;
    tick();
    check("midrst_load_busy",   {127'd0, load_busy},      128'd0);
    check("midrst_wr_ready",    {127'd0, wr_ready},       128'd0);
    check("midrst_instr_count", {112'd0, instr_count},    128'd0);
    check("midrst_ctrl_base",   {112'd0, ctrl_base_addr}, 128'd0);
    check("midrst_ctrl_length", {112'd0, ctrl_length},    128'd0);
    rst = 1'b0;
    q1.push_back(ev(EV_WRITE, 16'h0200, gemm_i));
    q1.push_back(ev(EV_WRITE, 16'h0201, end_i));
    q1.push_back(ev(EV_START, 16'h0200, 128'd2));
    begin_load(16'h0200);
    send_instr(gemm_i, 1'b0);
    send_instr(end_i, 1'b1);
    drain(1, 40);
    finish_run();

    // load_begin mid-instruction restarts the session at the new base.
    begin_load(16'h0500);
    send_word(end_i[31:0], 1'b0);
    send_word(end_i[63:32], 1'b0);
    q1.push_back(ev(EV_WRITE, 16'h0600, gemm_i));
    q1.push_back(ev(EV_WRITE, 16'h0601, end_i));
    q1.push_back(ev(EV_START, 16'h0600, 128'd2));
    begin_load(16'h0600);
    check("abort_instr_count", {112'd0, instr_count}, 128'd0);
    send_instr(gemm_i, 1'b0);
    send_instr(end_i, 1'b1);
    drain(1, 40);
    finish_run();

    // MAX_INSTR=2 instance: third instruction overflows.
    rst = 1'b1; rst2 = 1'b0; sel = 1'b1;
    tick();
    q2.push_back(ev(EV_WRITE, 16'h0700, gemm_i));
    q2.push_back(ev(EV_WRITE, 16'h0701, add_i));
    q2.push_back(ev(EV_ERROR, 16'd0, 128'd0));
    begin_load(16'h0700);
    send_instr(gemm_i, 1'b0);
    send_instr(add_i, 1'b0);
    send_instr(end_i, 1'b1);
    drain(2, 10);
    check("max_instr_count", {112'd0, instr_count2}, 128'd2);

    drain(1, 5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
